// File: rtl/clut_cache_multi.sv
// Multi-slot CLUT cache: round-robin victim fill over a level request, two 1-cycle registered read ports.
// Define CLUT_CACHE_STATS_EN to add saturating o_hitCount/o_missCount lookup counters.
module clut_cache_multi #(
    parameter int SLOTS = 4,
    parameter int ID_W  = 15
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic [ID_W-1:0] i_clutId,
    input  logic            i_is8bpp,
    input  logic            i_check,
    input  logic            i_invalidate,
    output logic            o_ready,
    output logic            o_fillReq,
    output logic [ID_W-1:0] o_fillId,
    output logic            o_fill8bpp,
    input  logic            i_fillValid,
    input  logic [31:0]     i_fillData,
    input  logic            i_rdReq1,
    input  logic [7:0]      i_rdIdx1,
    output logic [15:0]     o_color1,
    input  logic            i_rdReq2,
    input  logic [7:0]      i_rdIdx2,
    output logic [15:0]     o_color2
`ifdef CLUT_CACHE_STATS_EN
    ,
    output logic [15:0]     o_hitCount,
    output logic [15:0]     o_missCount
`endif
);

    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int AW = $clog2(SLOTS * 128);

    typedef enum logic {IDLE, FILL} state_t;
    state_t state, state_nxt;

    logic [SLOTS-1:0] tag_valid;
    logic [SLOTS-1:0] tag_full8;
    logic [ID_W-1:0]  tag_id [SLOTS];
    logic [31:0]      mem [SLOTS*128];

    logic [SW-1:0] rr_ptr, rr_inc, active, hit_slot;
    logic [6:0]    count;
    logic          stale;
    logic          hit_any, check_hit, start_fill, fill_wr, fill_done;
    logic [AW-1:0] wr_addr, rd_addr1, rd_addr2;
    logic [31:0]   rd_word1, rd_word2;

    // Lowest-numbered slot wins if the same id is resident twice (4bpp and 8bpp copies).
    always_comb begin
        hit_any  = 1'b0;
        hit_slot = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (tag_valid[s] && tag_id[s] == i_clutId && (tag_full8[s] || !i_is8bpp)) begin
                hit_any  = 1'b1;
                hit_slot = SW'(s);
            end
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        check_hit  = 1'b0;
        start_fill = 1'b0;
        fill_wr    = 1'b0;
        fill_done  = 1'b0;
        case (state)
            IDLE: begin
                if (i_check) begin
                    if (hit_any && !i_invalidate) begin
                        check_hit = 1'b1;
                    end else begin
                        start_fill = 1'b1;
                        state_nxt  = FILL;
                    end
                end
            end
            FILL: begin
                if (i_fillValid) begin
                    fill_wr = 1'b1;
                    if (count == (o_fill8bpp ? 7'd127 : 7'd7)) begin
                        fill_done = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rr_inc  = (rr_ptr == SW'(SLOTS - 1)) ? '0 : rr_ptr + SW'(1);
    assign wr_addr = AW'({rr_ptr, count});

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            tag_valid  <= '0;
            rr_ptr     <= '0;
            active     <= '0;
            count      <= '0;
            stale      <= 1'b0;
            o_ready    <= 1'b0;
            o_fillReq  <= 1'b0;
            o_fillId   <= '0;
            o_fill8bpp <= 1'b0;
        end else begin
            if (check_hit) begin
                active  <= hit_slot;
                o_ready <= 1'b1;
            end
            if (start_fill) begin
                tag_valid[rr_ptr] <= 1'b0;
                o_ready           <= 1'b0;
                o_fillReq         <= 1'b1;
                o_fillId          <= i_clutId;
                o_fill8bpp        <= i_is8bpp;
                count             <= '0;
                stale             <= 1'b0;
            end
            if (fill_wr) count <= count + 7'd1;
            if (fill_done) begin
                o_fillReq <= 1'b0;
                stale     <= 1'b0;
                rr_ptr    <= rr_inc;
                if (!stale && !i_invalidate) begin
                    tag_valid[rr_ptr] <= 1'b1;
                    active            <= rr_ptr;
                    o_ready           <= 1'b1;
                end
            end
            // Invalidate overrides everything above; a fill in flight finishes but stays invalid.
            if (i_invalidate) begin
                tag_valid <= '0;
                o_ready   <= 1'b0;
                if (state == FILL && !fill_done) stale <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_wr) mem[wr_addr] <= i_fillData;
        if (fill_done) begin
            tag_id[rr_ptr]    <= o_fillId;
            tag_full8[rr_ptr] <= o_fill8bpp;
        end
    end

    // Synchronous read: a same-cycle fill write to the same word returns the old contents.
    assign rd_addr1 = AW'({active, i_rdIdx1[7:1]});
    assign rd_addr2 = AW'({active, i_rdIdx2[7:1]});
    assign rd_word1 = mem[rd_addr1];
    assign rd_word2 = mem[rd_addr2];

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_color1 <= '0;
            o_color2 <= '0;
        end else begin
            if (i_rdReq1) o_color1 <= i_rdIdx1[0] ? rd_word1[31:16] : rd_word1[15:0];
            if (i_rdReq2) o_color2 <= i_rdIdx2[0] ? rd_word2[31:16] : rd_word2[15:0];
        end
    end

`ifdef CLUT_CACHE_STATS_EN
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_hitCount  <= '0;
            o_missCount <= '0;
        end else begin
            if (check_hit && o_hitCount != 16'hFFFF)   o_hitCount  <= o_hitCount + 16'd1;
            if (start_fill && o_missCount != 16'hFFFF) o_missCount <= o_missCount + 16'd1;
        end
    end
`endif

endmodule
